// File: rtl/memory_access_pkg.sv
// RV32I encodings shared by decode, memory access and writeback.
package memory_access_pkg;

    // Major opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LCC    = 7'b0000011;
    localparam logic [6:0] OP_SCC    = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    // Load / store widths (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } mem_state_e;

    // Natural alignment check: size comes from funct3[1:0].
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~a[0];
            default: return (a == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/memory_access_lsu_align.sv
// Byte-lane steering: store byte enables / replicated data and load extraction.
module lsu_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);
    logic [31:0] shifted;

    // Store side: enables follow size and lane, data replicated across lanes.
    always_comb begin
        be    = 4'b1111;
        wdata = rs2;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{rs2[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{rs2[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: bring the addressed lane to bit 0, then extend.
    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_LB:   ldata = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   ldata = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  ldata = {24'h0, shifted[7:0]};
            F3_LHU:  ldata = {16'h0, shifted[15:0]};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage: drives the data-memory port, stalls upstream while an access
// is in flight, and owns the MEM/WB pipeline register.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int          XLEN   = 32,
    parameter logic [31:0] RST_PC = 32'h0
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic            EX_MEM_valid,
    input  logic [XLEN-1:0] EX_MEM_pc,
    input  logic [31:0]     EX_MEM_inst,
    input  logic [XLEN-1:0] EX_MEM_alu,
    input  logic [4:0]      EX_MEM_rd,
    input  logic [XLEN-1:0] EX_MEM_rs2,
    output logic            MEM_stall,
    output logic            DMEM_req,
    output logic            DMEM_we,
    output logic [XLEN-1:0] DMEM_addr,
    output logic [XLEN-1:0] DMEM_wdata,
    output logic [3:0]      DMEM_be,
    input  logic            DMEM_gnt,
    input  logic            DMEM_rvalid,
    input  logic [XLEN-1:0] DMEM_rdata,
    output logic            MEM_WB_valid,
    output logic [XLEN-1:0] MEM_WB_pc,
    output logic [31:0]     MEM_WB_inst,
    output logic [XLEN-1:0] MEM_WB_alu,
    output logic [4:0]      MEM_WB_rd,
    output logic [XLEN-1:0] MEM_WB_data,
    output logic            MEM_misalign
);
    mem_state_e  state, state_nxt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_store, is_mem, aligned, memop, done;
    logic [31:0] ldata;

    assign opcode   = EX_MEM_inst[6:0];
    assign funct3   = EX_MEM_inst[14:12];
    assign is_load  = EX_MEM_valid & (opcode == OP_LCC);
    assign is_store = EX_MEM_valid & (opcode == OP_SCC);
    assign is_mem   = is_load | is_store;
    assign aligned  = is_aligned(funct3, EX_MEM_alu[1:0]);
    assign memop    = is_mem & aligned;

    assign DMEM_we   = is_store;
    assign DMEM_addr = {EX_MEM_alu[31:2], 2'b00};
    assign MEM_stall = memop & ~done;

    lsu_align u_align (
        .funct3  (funct3),
        .addr_lo (EX_MEM_alu[1:0]),
        .rs2     (EX_MEM_rs2),
        .rdata   (DMEM_rdata),
        .be      (DMEM_be),
        .wdata   (DMEM_wdata),
        .ldata   (ldata)
    );

    // Access FSM state register.
    always_ff @(posedge CLK) begin
        if (RES) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state, request and completion; stores finish on gnt, loads on rvalid.
    always_comb begin
        state_nxt = state;
        DMEM_req  = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE, S_REQ: begin
                if (memop) begin
                    DMEM_req = 1'b1;
                    if (DMEM_gnt) begin
                        if (is_store) begin
                            done      = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt = S_WAIT;
                        end
                    end else begin
                        state_nxt = S_REQ;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (DMEM_rvalid) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // MEM/WB register: capture on completion or non-memory op, else bubble.
    always_ff @(posedge CLK) begin
        if (RES) begin
            MEM_WB_valid <= 1'b0;
            MEM_WB_pc    <= RST_PC;
            MEM_WB_inst  <= NOP_INST;
            MEM_WB_alu   <= '0;
            MEM_WB_rd    <= '0;
            MEM_WB_data  <= '0;
            MEM_misalign <= 1'b0;
        end else begin
            MEM_misalign <= is_mem & ~aligned;
            if (done || (EX_MEM_valid && !is_mem)) begin
                MEM_WB_valid <= 1'b1;
                MEM_WB_pc    <= EX_MEM_pc;
                MEM_WB_inst  <= EX_MEM_inst;
                MEM_WB_alu   <= EX_MEM_alu;
                MEM_WB_rd    <= EX_MEM_rd;
                MEM_WB_data  <= is_load ? ldata : EX_MEM_alu;
            end else begin
                MEM_WB_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the MEM stage: ALU pass-through, stores, loads with
// delayed handshakes, misalignment, reset mid-access and back-to-back ops.
module tb_memory_access;
    logic        CLK = 1'b0;
    logic        RES;
    logic        EX_MEM_valid;
    logic [31:0] EX_MEM_pc, EX_MEM_inst, EX_MEM_alu, EX_MEM_rs2;
    logic [4:0]  EX_MEM_rd;
    logic        MEM_stall, DMEM_req, DMEM_we;
    logic [31:0] DMEM_addr, DMEM_wdata;
    logic [3:0]  DMEM_be;
    logic        DMEM_gnt, DMEM_rvalid;
    logic [31:0] DMEM_rdata;
    logic        MEM_WB_valid;
    logic [31:0] MEM_WB_pc, MEM_WB_inst, MEM_WB_alu, MEM_WB_data;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_misalign;

    int n_checks = 0;
    int n_fail   = 0;

    memory_access #(.XLEN(32), .RST_PC(32'h0)) dut (
        .CLK(CLK), .RES(RES),
        .EX_MEM_valid(EX_MEM_valid), .EX_MEM_pc(EX_MEM_pc), .EX_MEM_inst(EX_MEM_inst),
        .EX_MEM_alu(EX_MEM_alu), .EX_MEM_rd(EX_MEM_rd), .EX_MEM_rs2(EX_MEM_rs2),
        .MEM_stall(MEM_stall), .DMEM_req(DMEM_req), .DMEM_we(DMEM_we),
        .DMEM_addr(DMEM_addr), .DMEM_wdata(DMEM_wdata), .DMEM_be(DMEM_be),
        .DMEM_gnt(DMEM_gnt), .DMEM_rvalid(DMEM_rvalid), .DMEM_rdata(DMEM_rdata),
        .MEM_WB_valid(MEM_WB_valid), .MEM_WB_pc(MEM_WB_pc), .MEM_WB_inst(MEM_WB_inst),
        .MEM_WB_alu(MEM_WB_alu), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_data(MEM_WB_data),
        .MEM_misalign(MEM_misalign)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        return {17'h0, f3, rd, op};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rs2);
        EX_MEM_valid = 1'b1;
        EX_MEM_inst  = inst;
        EX_MEM_pc    = pc;
        EX_MEM_alu   = alu;
        EX_MEM_rs2   = rs2;
        EX_MEM_rd    = inst[11:7];
    endtask

    task automatic test_reset();
        RES = 1'b1; EX_MEM_valid = 1'b0; EX_MEM_inst = 32'h0; EX_MEM_pc = 32'h0;
        EX_MEM_alu = 32'h0; EX_MEM_rs2 = 32'h0; EX_MEM_rd = 5'd0;
        DMEM_gnt = 1'b0; DMEM_rvalid = 1'b0; DMEM_rdata = 32'h0;
        tick(); tick();
        RES = 1'b0;
        #1;
        n_checks++; if (MEM_WB_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", MEM_WB_valid); end
        n_checks++; if (MEM_WB_inst !== 32'h13) begin n_fail++; $display("FAIL reset_inst got %h want 00000013", MEM_WB_inst); end
        n_checks++; if (MEM_WB_pc !== 32'h0 || MEM_WB_data !== 32'h0 || MEM_WB_rd !== 5'd0 || MEM_WB_alu !== 32'h0)
            begin n_fail++; $display("FAIL reset_fields pc %h data %h rd %0d alu %h want zeros", MEM_WB_pc, MEM_WB_data, MEM_WB_rd, MEM_WB_alu); end
        n_checks++; if (MEM_misalign !== 1'b0 || DMEM_req !== 1'b0 || MEM_stall !== 1'b0)
            begin n_fail++; $display("FAIL reset_ctrl mis %0b req %0b stall %0b want 0", MEM_misalign, DMEM_req, MEM_stall); end
        tick();
    endtask

    task automatic test_alu();
        drive(32'h05500293, 32'h40, 32'h55, 32'h0);   // addi x5, x0, 0x55
        #1;
        n_checks++; if (MEM_stall !== 1'b0 || DMEM_req !== 1'b0)
            begin n_fail++; $display("FAIL alu_nostall stall %0b req %0b want 0", MEM_stall, DMEM_req); end
        tick();
        EX_MEM_valid = 1'b0;
        n_checks++; if (MEM_WB_valid !== 1'b1 || MEM_WB_data !== 32'h55 || MEM_WB_rd !== 5'd5 || MEM_WB_pc !== 32'h40 || MEM_WB_inst !== 32'h05500293)
            begin n_fail++; $display("FAIL alu_wb valid %0b data %h rd %0d pc %h want 1 55 5 40", MEM_WB_valid, MEM_WB_data, MEM_WB_rd, MEM_WB_pc); end
        tick();
        n_checks++; if (MEM_WB_valid !== 1'b0) begin n_fail++; $display("FAIL alu_bubble got %0b want 0", MEM_WB_valid); end
    endtask

    task automatic test_store();
        drive(mk(7'h23, 3'b010, 5'd0), 32'h44, 32'h100, 32'hDEADBEEF);
        DMEM_gnt = 1'b1;
        #1;
        n_checks++; if (DMEM_req !== 1'b1 || DMEM_we !== 1'b1 || MEM_stall !== 1'b0)
            begin n_fail++; $display("FAIL sw_ctrl req %0b we %0b stall %0b want 1 1 0", DMEM_req, DMEM_we, MEM_stall); end
        n_checks++; if (DMEM_be !== 4'b1111 || DMEM_wdata !== 32'hDEADBEEF || DMEM_addr !== 32'h100)
            begin n_fail++; $display("FAIL sw_port be %b wdata %h addr %h want 1111 deadbeef 100", DMEM_be, DMEM_wdata, DMEM_addr); end
        tick();
        DMEM_gnt = 1'b0; EX_MEM_valid = 1'b0;
        n_checks++; if (MEM_WB_valid !== 1'b1 || MEM_WB_data !== 32'h100 || MEM_WB_pc !== 32'h44)
            begin n_fail++; $display("FAIL sw_wb valid %0b data %h pc %h want 1 100 44", MEM_WB_valid, MEM_WB_data, MEM_WB_pc); end
        tick();
    endtask

    task automatic test_load_delayed();
        drive(mk(7'h03, 3'b000, 5'd7), 32'h48, 32'h203, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (DMEM_req !== 1'b1 || MEM_stall !== 1'b1 || DMEM_addr !== 32'h200 || DMEM_we !== 1'b0)
                begin n_fail++; $display("FAIL lb_req%0d req %0b stall %0b addr %h want 1 1 200", i, DMEM_req, MEM_stall, DMEM_addr); end
            tick();
        end
        DMEM_gnt = 1'b1;
        #1;
        n_checks++; if (DMEM_req !== 1'b1 || MEM_stall !== 1'b1)
            begin n_fail++; $display("FAIL lb_gnt req %0b stall %0b want 1 1", DMEM_req, MEM_stall); end
        tick();
        DMEM_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (DMEM_req !== 1'b0 || MEM_stall !== 1'b1 || MEM_WB_valid !== 1'b0)
                begin n_fail++; $display("FAIL lb_wait%0d req %0b stall %0b wbv %0b want 0 1 0", i, DMEM_req, MEM_stall, MEM_WB_valid); end
            tick();
        end
        DMEM_rvalid = 1'b1; DMEM_rdata = 32'h80FF1122;
        #1;
        n_checks++; if (MEM_stall !== 1'b0) begin n_fail++; $display("FAIL lb_release stall %0b want 0", MEM_stall); end
        tick();
        DMEM_rvalid = 1'b0; EX_MEM_valid = 1'b0;
        n_checks++; if (MEM_WB_valid !== 1'b1 || MEM_WB_data !== 32'hFFFFFF80 || MEM_WB_rd !== 5'd7)
            begin n_fail++; $display("FAIL lb_wb valid %0b data %h rd %0d want 1 ffffff80 7", MEM_WB_valid, MEM_WB_data, MEM_WB_rd); end
        tick();
    endtask

    task automatic test_lhu_sh();
        drive(mk(7'h03, 3'b101, 5'd8), 32'h4C, 32'h202, 32'h0);
        DMEM_gnt = 1'b1;
        tick();
        DMEM_gnt = 1'b0; DMEM_rvalid = 1'b1; DMEM_rdata = 32'h80FF1122;
        tick();
        DMEM_rvalid = 1'b0;
        n_checks++; if (MEM_WB_valid !== 1'b1 || MEM_WB_data !== 32'h000080FF)
            begin n_fail++; $display("FAIL lhu_wb valid %0b data %h want 1 000080ff", MEM_WB_valid, MEM_WB_data); end
        drive(mk(7'h23, 3'b001, 5'd0), 32'h50, 32'h202, 32'h00001234);
        DMEM_gnt = 1'b1;
        #1;
        n_checks++; if (DMEM_be !== 4'b1100 || DMEM_wdata !== 32'h12341234 || DMEM_req !== 1'b1)
            begin n_fail++; $display("FAIL sh_port be %b wdata %h req %0b want 1100 12341234 1", DMEM_be, DMEM_wdata, DMEM_req); end
        drive(mk(7'h23, 3'b000, 5'd0), 32'h50, 32'h203, 32'h000000A5);
        #1;
        n_checks++; if (DMEM_be !== 4'b1000 || DMEM_wdata !== 32'hA5A5A5A5)
            begin n_fail++; $display("FAIL sb_port be %b wdata %h want 1000 a5a5a5a5", DMEM_be, DMEM_wdata); end
        tick();
        DMEM_gnt = 1'b0; EX_MEM_valid = 1'b0;
        tick();
    endtask

    task automatic test_misalign();
        drive(mk(7'h03, 3'b010, 5'd9), 32'h54, 32'h101, 32'h0);
        #1;
        n_checks++; if (DMEM_req !== 1'b0 || MEM_stall !== 1'b0)
            begin n_fail++; $display("FAIL mis_noreq req %0b stall %0b want 0 0", DMEM_req, MEM_stall); end
        tick();
        EX_MEM_valid = 1'b0;
        n_checks++; if (MEM_misalign !== 1'b1 || MEM_WB_valid !== 1'b0)
            begin n_fail++; $display("FAIL mis_pulse mis %0b wbv %0b want 1 0", MEM_misalign, MEM_WB_valid); end
        tick();
        n_checks++; if (MEM_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_clear got %0b want 0", MEM_misalign); end
    endtask

    task automatic test_reset_wait();
        drive(mk(7'h03, 3'b010, 5'd10), 32'h58, 32'h300, 32'h0);
        DMEM_gnt = 1'b1;
        tick();
        DMEM_gnt = 1'b0;
        #1;
        n_checks++; if (DMEM_req !== 1'b0 || MEM_stall !== 1'b1)
            begin n_fail++; $display("FAIL rstw_wait req %0b stall %0b want 0 1", DMEM_req, MEM_stall); end
        RES = 1'b1;
        tick();
        RES = 1'b0; EX_MEM_valid = 1'b0;
        DMEM_rvalid = 1'b1; DMEM_rdata = 32'hCAFEF00D;
        #1;
        n_checks++; if (DMEM_req !== 1'b0 || MEM_stall !== 1'b0)
            begin n_fail++; $display("FAIL rstw_idle req %0b stall %0b want 0 0", DMEM_req, MEM_stall); end
        tick();
        DMEM_rvalid = 1'b0;
        n_checks++; if (MEM_WB_valid !== 1'b0 || MEM_WB_data !== 32'h0 || MEM_WB_inst !== 32'h13)
            begin n_fail++; $display("FAIL rstw_nowrite valid %0b data %h inst %h want 0 0 13", MEM_WB_valid, MEM_WB_data, MEM_WB_inst); end
    endtask

    task automatic test_back_to_back();
        // kind 0 = ADD, 1 = SW, 2 = LW; expected data: LW -> rdata, else alu
        int          kind  [6] = '{2, 1, 0, 2, 0, 1};
        logic [31:0] alu   [6] = '{32'h400, 32'h404, 32'h1234, 32'h408, 32'h77, 32'h40C};
        logic [31:0] rdat  [6] = '{32'h11112222, 32'h0, 32'h0, 32'h9ABCDEF0, 32'h0, 32'h0};
        logic [31:0] inst;
        logic [31:0] expd;
        int d1, d2;
        for (int i = 0; i < 6; i++) begin
            inst = (kind[i] == 2) ? mk(7'h03, 3'b010, 5'd11) :
                   (kind[i] == 1) ? mk(7'h23, 3'b010, 5'd0) : mk(7'h33, 3'b000, 5'd12);
            expd = (kind[i] == 2) ? rdat[i] : alu[i];
            drive(inst, 32'h100 + 32'(i * 4), alu[i], 32'h5A5A0000 + 32'(i));
            d1 = (kind[i] == 0) ? 0 : int'($urandom_range(0, 3));
            d2 = int'($urandom_range(0, 3));
            for (int c = 0; c < d1; c++) begin
                #1;
                n_checks++; if (MEM_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_gntwait i%0d stall %0b want 1", i, MEM_stall); end
                tick();
            end
            if (kind[i] != 0) DMEM_gnt = 1'b1;
            if (kind[i] == 2) begin
                #1;
                n_checks++; if (MEM_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt i%0d stall %0b want 1", i, MEM_stall); end
                tick();
                DMEM_gnt = 1'b0;
                for (int c = 0; c < d2; c++) begin
                    #1;
                    n_checks++; if (MEM_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_rwait i%0d stall %0b want 1", i, MEM_stall); end
                    tick();
                end
                DMEM_rvalid = 1'b1; DMEM_rdata = rdat[i];
            end
            #1;
            n_checks++; if (MEM_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done i%0d stall %0b want 0", i, MEM_stall); end
            tick();
            DMEM_gnt = 1'b0; DMEM_rvalid = 1'b0;
            n_checks++; if (MEM_WB_valid !== 1'b1 || MEM_WB_pc !== 32'h100 + 32'(i * 4) || MEM_WB_data !== expd)
                begin n_fail++; $display("FAIL b2b_wb i%0d valid %0b pc %h data %h want 1 %h %h", i, MEM_WB_valid, MEM_WB_pc, MEM_WB_data, 32'h100 + 32'(i * 4), expd); end
        end
        EX_MEM_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load_delayed();
        test_lhu_sh();
        test_misalign();
        test_reset_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
